// File: rtl/dlf_pkg.sv
// Shared types, error encoding and saturation-bound helpers for the digital loop filter.
package dlf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } lock_state_e;

  // Two's-complement codes for the per-clock phase error.
  localparam logic [1:0] ERR_ZERO = 2'b00;
  localparam logic [1:0] ERR_POS  = 2'b01;
  localparam logic [1:0] ERR_NEG  = 2'b11;

  function automatic logic [1:0] err_encode(input logic up_bit, input logic dn_bit);
    logic [1:0] code;
    case ({up_bit, dn_bit})
      2'b10:   code = ERR_POS;
      2'b01:   code = ERR_NEG;
      default: code = ERR_ZERO;
    endcase
    return code;
  endfunction

  function automatic int ctrl_upper(input int cw);
    return (32'sd1 <<< cw) - 32'sd1;
  endfunction

  function automatic int acc_upper(input int cw, input int frac_w, input int center);
    return (ctrl_upper(cw) - center) <<< frac_w;
  endfunction

  function automatic int acc_lower(input int frac_w, input int center);
    return -(center <<< frac_w);
  endfunction

endpackage

// File: rtl/pfd_sync.sv
// Two-flop synchronizer bank bringing the asynchronous PFD pulses into the filter clock domain.
module pfd_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two capture stages per bit; the first stage may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign dout = sync_r;

endmodule

// File: rtl/digital_loop_filter.sv
// Proportional-integral loop filter turning PFD up/dn pulses into a saturated DCO control word,
// with a windowed lock detector.
module digital_loop_filter
  import dlf_pkg::*;
#(
  parameter int CW          = 10,
  parameter int FRAC_W      = 6,
  parameter int KP_SHIFT    = 4,
  parameter int KI_SHIFT    = 0,
  parameter int CENTER      = 512,
  parameter int LOCK_WINDOW = 64,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic          clk,
  input  logic          ext_rst,
  input  logic          enable,
  input  logic          freeze,
  input  logic          up,
  input  logic          dn,
  output logic [CW-1:0] ctrl_word,
  output logic          lock,
  output logic [1:0]    lock_state
);

  localparam int AW    = CW + FRAC_W + 1;
  localparam int WW    = CW + 2;
  localparam int WIN_W = $clog2(LOCK_WINDOW);
  localparam int ECW   = $clog2(LOCK_TOL + 2);
  localparam int QW    = $clog2(LOCK_COUNT + 1);

  localparam logic signed [AW-1:0] ACC_MAX  = AW'(acc_upper(CW, FRAC_W, CENTER));
  localparam logic signed [AW-1:0] ACC_MIN  = AW'(acc_lower(FRAC_W, CENTER));
  localparam logic signed [WW-1:0] CENTER_W = WW'(CENTER);
  localparam logic signed [WW-1:0] CMAX_W   = WW'(ctrl_upper(CW));
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(LOCK_WINDOW - 1);
  localparam logic [ECW-1:0]       ERR_SAT  = ECW'(LOCK_TOL + 1);
  localparam logic [ECW-1:0]       ERR_TOL  = ECW'(LOCK_TOL);
  localparam logic [QW-1:0]        Q_LAST   = QW'(LOCK_COUNT - 1);

  logic [1:0]           sync_s;
  logic [1:0]           err_s;
  logic signed [AW-1:0] acc_r, acc_next_s, acc_sum_s, acc_int_s;
  logic signed [WW-1:0] prop_s, sum_s;
  logic [CW-1:0]        ctrl_r, ctrl_next_s;

  lock_state_e          state_r, state_next_s;
  logic [WIN_W-1:0]     win_r, win_next_s;
  logic [ECW-1:0]       errc_r, errc_next_s, errc_inc_s;
  logic [QW-1:0]        quiet_r, quiet_next_s;
  logic                 lock_r, lock_next_s;
  logic                 win_end_s, quiet_win_s, err_nz_s;

  pfd_sync #(.W(2)) u_sync (
    .clk  (clk),
    .rst  (ext_rst),
    .din  ({up, dn}),
    .dout (sync_s)
  );

  assign err_s     = err_encode(sync_s[1], sync_s[0]);
  assign acc_sum_s = acc_r + (AW'($signed(err_s)) <<< KI_SHIFT);

  // Integrator update with clamping, then the saturated control word.
  always_comb begin
    acc_next_s  = acc_r;
    prop_s      = '0;
    ctrl_next_s = CW'(CENTER);
    if (!enable) begin
      acc_next_s = '0;
    end else if (freeze) begin
      acc_next_s = acc_r;
    end else begin
      prop_s = WW'($signed(err_s)) <<< KP_SHIFT;
      if (acc_sum_s > ACC_MAX) begin
        acc_next_s = ACC_MAX;
      end else if (acc_sum_s < ACC_MIN) begin
        acc_next_s = ACC_MIN;
      end else begin
        acc_next_s = acc_sum_s;
      end
    end
    acc_int_s = acc_next_s >>> FRAC_W;
    sum_s     = CENTER_W + $signed(acc_int_s[WW-1:0]) + prop_s;
    if (!enable) begin
      ctrl_next_s = CW'(CENTER);
    end else if (sum_s[WW-1]) begin
      ctrl_next_s = '0;
    end else if (sum_s > CMAX_W) begin
      ctrl_next_s = CMAX_W[CW-1:0];
    end else begin
      ctrl_next_s = sum_s[CW-1:0];
    end
  end

  assign err_nz_s    = (err_s != ERR_ZERO);
  assign errc_inc_s  = (err_nz_s && (errc_r != ERR_SAT)) ? errc_r + ECW'(1) : errc_r;
  assign win_end_s   = (win_r == WIN_LAST);
  assign quiet_win_s = (errc_inc_s <= ERR_TOL);

  // Lock detector next-state: window bookkeeping and transition priority.
  always_comb begin
    state_next_s = state_r;
    win_next_s   = win_r;
    errc_next_s  = errc_r;
    quiet_next_s = quiet_r;
    lock_next_s  = lock_r;
    if (!enable) begin
      state_next_s = IDLE;
      win_next_s   = '0;
      errc_next_s  = '0;
      quiet_next_s = '0;
      lock_next_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = ACQUIRE;
          win_next_s   = '0;
          errc_next_s  = '0;
          quiet_next_s = '0;
          lock_next_s  = 1'b0;
        end
        ACQUIRE, LOCKED: begin
          if (freeze) begin
            state_next_s = HOLD;
          end else if (win_end_s) begin
            win_next_s  = '0;
            errc_next_s = '0;
            if (!quiet_win_s) begin
              state_next_s = ACQUIRE;
              quiet_next_s = '0;
              lock_next_s  = 1'b0;
            end else if (state_r == ACQUIRE && quiet_r == Q_LAST) begin
              state_next_s = LOCKED;
              quiet_next_s = '0;
              lock_next_s  = 1'b1;
            end else if (state_r == ACQUIRE) begin
              quiet_next_s = quiet_r + QW'(1);
            end else begin
              quiet_next_s = quiet_r;
            end
          end else begin
            win_next_s  = win_r + WIN_W'(1);
            errc_next_s = errc_inc_s;
          end
        end
        HOLD: begin
          if (!freeze) begin
            state_next_s = ACQUIRE;
            win_next_s   = '0;
            errc_next_s  = '0;
            lock_next_s  = 1'b0;
          end else begin
            state_next_s = HOLD;
          end
        end
        default: begin
          state_next_s = IDLE;
          lock_next_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (ext_rst) begin
      acc_r   <= '0;
      ctrl_r  <= CW'(CENTER);
      state_r <= IDLE;
      win_r   <= '0;
      errc_r  <= '0;
      quiet_r <= '0;
      lock_r  <= 1'b0;
    end else begin
      acc_r   <= acc_next_s;
      ctrl_r  <= ctrl_next_s;
      state_r <= state_next_s;
      win_r   <= win_next_s;
      errc_r  <= errc_next_s;
      quiet_r <= quiet_next_s;
      lock_r  <= lock_next_s;
    end
  end

  assign ctrl_word  = ctrl_r;
  assign lock       = lock_r;
  assign lock_state = state_r;

endmodule

// File: tb/tb_digital_loop_filter.sv
// Directed self-checking bench for digital_loop_filter using hand-computed expected values.
module tb_digital_loop_filter;

  logic       clk = 1'b0;
  logic       ext_rst = 1'b1;
  logic       enable = 1'b1;
  logic       freeze = 1'b0;
  logic       up = 1'b0;
  logic       dn = 1'b0;
  logic [9:0] ctrl_word;
  logic       lock;
  logic [1:0] lock_state;

  int checks = 0;
  int failures = 0;

  digital_loop_filter dut (
    .clk        (clk),
    .ext_rst    (ext_rst),
    .enable     (enable),
    .freeze     (freeze),
    .up         (up),
    .dn         (dn),
    .ctrl_word  (ctrl_word),
    .lock       (lock),
    .lock_state (lock_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ext_rst = 1'b1;
    step(2);
    ext_rst = 1'b0;
  endtask

  initial begin
    // Reset state and entry into ACQUIRE
    step(2);
    check_eq("rst_ctrl", 32'(ctrl_word), 32'd512);
    check_eq("rst_lock", 32'(lock), 32'd0);
    check_eq("rst_state", 32'(lock_state), 32'd0);
    ext_rst = 1'b0;
    step(1);
    check_eq("acq_entry", 32'(lock_state), 32'd1);

    // Quiet loop locks at the 4th window end, 256 edges after entering ACQUIRE
    step(255);
    check_eq("prelock_lock", 32'(lock), 32'd0);
    check_eq("prelock_state", 32'(lock_state), 32'd1);
    step(1);
    check_eq("lock_lock", 32'(lock), 32'd1);
    check_eq("lock_state", 32'(lock_state), 32'd2);

    // Three single-clock up pulses inside the next window break lock at its end
    for (int i = 0; i < 3; i++) begin
      up = 1'b1;
      step(1);
      up = 1'b0;
      step(2);
    end
    step(54);
    check_eq("noisy_before_end", 32'(lock), 32'd1);
    step(1);
    check_eq("unlock_lock", 32'(lock), 32'd0);
    check_eq("unlock_state", 32'(lock_state), 32'd1);
    check_eq("unlock_ctrl", 32'(ctrl_word), 32'd512);

    // Relock, then freeze with up held: control word frozen, HOLD keeps lock
    step(255);
    check_eq("relock_pre", 32'(lock), 32'd0);
    step(1);
    check_eq("relock_lock", 32'(lock), 32'd1);
    freeze = 1'b1;
    up = 1'b1;
    step(1);
    check_eq("hold_state", 32'(lock_state), 32'd3);
    check_eq("hold_lock", 32'(lock), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(25);
      check_eq("hold_ctrl", 32'(ctrl_word), 32'd512);
    end
    check_eq("hold_state_end", 32'(lock_state), 32'd3);
    check_eq("hold_lock_end", 32'(lock), 32'd1);
    freeze = 1'b0;
    up = 1'b0;
    step(1);
    check_eq("unhold_state", 32'(lock_state), 32'd1);
    check_eq("unhold_lock", 32'(lock), 32'd0);
    enable = 1'b0;
    step(1);
    check_eq("dis_ctrl", 32'(ctrl_word), 32'd512);
    check_eq("dis_state", 32'(lock_state), 32'd0);
    check_eq("dis_lock", 32'(lock), 32'd0);
    enable = 1'b1;

    // 8 clocks of up: proportional kick of 16 with two-edge latency
    do_reset();
    up = 1'b1;
    step(2);
    check_eq("up8_latency", 32'(ctrl_word), 32'd512);
    step(1);
    check_eq("up8_first", 32'(ctrl_word), 32'd528);
    step(5);
    up = 1'b0;
    step(2);
    check_eq("up8_last", 32'(ctrl_word), 32'd528);
    step(1);
    check_eq("up8_after", 32'(ctrl_word), 32'd512);

    // 64 clocks of up, then mirror with dn
    do_reset();
    up = 1'b1;
    step(64);
    up = 1'b0;
    step(2);
    check_eq("up64_last", 32'(ctrl_word), 32'd529);
    step(1);
    check_eq("up64_after", 32'(ctrl_word), 32'd513);
    do_reset();
    dn = 1'b1;
    step(64);
    dn = 1'b0;
    step(2);
    check_eq("dn64_last", 32'(ctrl_word), 32'd495);
    step(1);
    check_eq("dn64_after", 32'(ctrl_word), 32'd511);

    // Simultaneous up and dn produce no error
    do_reset();
    up = 1'b1;
    dn = 1'b1;
    step(12);
    check_eq("both_ctrl", 32'(ctrl_word), 32'd512);
    up = 1'b0;
    dn = 1'b0;
    step(3);
    check_eq("both_after", 32'(ctrl_word), 32'd512);

    // Saturation: up held well past the integrator limit, then one dn clock
    do_reset();
    up = 1'b1;
    step(32726);
    check_eq("sat_ctrl", 32'(ctrl_word), 32'd1023);
    up = 1'b0;
    dn = 1'b1;
    step(1);
    dn = 1'b0;
    step(1);
    check_eq("sat_hold", 32'(ctrl_word), 32'd1023);
    step(1);
    check_eq("sat_dn", 32'(ctrl_word), 32'd1006);
    step(1);
    check_eq("sat_settle", 32'(ctrl_word), 32'd1022);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digital_loop_filter.md
Name: digital_loop_filter

Overview:
- Consumes the asynchronous up/dn pulse pair from the phase-frequency detector.
- Converts pulse width into a signed per-clock error and runs a proportional-integral filter.
- Emits a saturated control word that tunes the DCO.
- Includes a windowed lock detector FSM that reports loop lock to the SERDES control logic.

Parameters:
- CW, 10, control word width in bits.
- FRAC_W, 6, fractional bits held below the integer LSB of the integrator.
- KP_SHIFT, 4, proportional gain: ctrl LSBs per error sample = 2^KP_SHIFT.
- KI_SHIFT, 0, integral gain: integrator increment per error sample = 2^KI_SHIFT fractional LSBs.
- CENTER, 512, free-running control word, used on reset and while disabled.
- LOCK_WINDOW, 64, clocks per lock-evaluation window.
- LOCK_TOL, 2, maximum error samples per window for the window to count as quiet.
- LOCK_COUNT, 4, consecutive quiet windows required to declare lock.

Ports:
- clk, in, 1, filter clock.
- ext_rst, in, 1, synchronous active-high reset.
- enable, in, 1, loop enable.
- freeze, in, 1, hold integrator; proportional path forced to 0.
- up, in, 1, PFD up pulse (asynchronous to clk).
- dn, in, 1, PFD dn pulse (asynchronous to clk).
- ctrl_word, out, CW, DCO tuning word (registered).
- lock, out, 1, loop locked (registered).
- lock_state, out, 2, FSM state: 0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 HOLD.

Behaviour:
- Reset (ext_rst high at a clk edge) sets:
  - synchronizers 0, integrator 0, window and quiet counters 0;
  - ctrl_word = CENTER, lock = 0, lock_state = IDLE.
- Synchronization: up and dn each pass through a 2-flop synchronizer.
- Error per clock, from the synchronized values:
  - up_s & ~dn_s gives err = +1;
  - dn_s & ~up_s gives err = -1;
  - both or neither gives err = 0.
- Latency: a level captured at edge k is reflected in ctrl_word after edge k+2.
- Integrator:
  - signed, CW+FRAC_W+1 bits;
  - acc_next = acc + err·2^KI_SHIFT;
  - clamped to [-(CENTER<<FRAC_W), (2^CW-1-CENTER)<<FRAC_W].
- Proportional term: prop = err·2^KP_SHIFT.
- Control word: ctrl_word <= clamp(CENTER + (acc_next >>> FRAC_W) + prop, 0, 2^CW-1).
  - Compute in CW+2 signed bits before clamping.
  - The arithmetic shift floors toward minus infinity.
- Freeze: acc holds and prop = 0, so ctrl_word = CENTER + (acc>>>FRAC_W). Synchronizers keep running.
- Enable low: acc cleared, ctrl_word = CENTER, FSM forced to IDLE, lock = 0.
- Window counter:
  - counts 0..LOCK_WINDOW-1 while in ACQUIRE or LOCKED;
  - err_cnt counts clocks with err≠0, saturating at LOCK_TOL+1;
  - at the window-end edge (counter = LOCK_WINDOW-1) both counters reset;
  - the window is quiet if err_cnt, including that final cycle's sample, is ≤ LOCK_TOL.
- FSM transitions (checked in order, first match wins):
  - any state, enable=0 → IDLE;
  - IDLE, enable=1 → ACQUIRE (quiet counter cleared);
  - ACQUIRE, freeze=1 → HOLD;
  - ACQUIRE, quiet window end → quiet_cnt+1; when it reaches LOCK_COUNT → LOCKED, with lock=1 at that same edge;
  - ACQUIRE, non-quiet window end → quiet_cnt = 0;
  - LOCKED, freeze=1 → HOLD, lock stays 1;
  - LOCKED, non-quiet window end → ACQUIRE, lock=0, quiet_cnt = 0;
  - HOLD, freeze=0 → ACQUIRE, window counters cleared, lock=0.
- Counters in HOLD: window counters do not advance.
- Simultaneous up and dn (PFD reset overlap): err = 0, no integrator or lock effect.
- Reset mid-operation: every register returns to its reset value on that edge, with no partial update.

Decomposition:
- Package dlf_pkg holds:
  - lock_state enum (IDLE, ACQUIRE, LOCKED, HOLD);
  - err encoding constants;
  - saturation-bound helper functions.
- One sub-module, pfd_sync: a 2-flop synchronizer for up and dn, instantiated once for both bits.
- Lock detector stays inline.

Test Plan:
1. Assert ext_rst for 2 clocks with enable=1 → ctrl_word=512, lock=0, lock_state=0; after release, lock_state=1 on the next edge.
2. up high for 8 clocks, defaults → ctrl_word=528 for 8 clocks starting 2 edges after the first sample, then 512 (acc=8, integer part 0).
3. up high for 64 clocks → final ctrl_word=529, then 513 once up falls. Mirror test with dn high for 64 clocks from reset → 495, then 511.
4. up held until saturation (≈32704 clocks) → ctrl_word clamps at 1023, acc clamps at 511<<6; one dn clock → ctrl_word=1006.
5. up=dn=0 after enable → lock=1 and lock_state=2 at the 4th window end (256 clocks after entering ACQUIRE). Then 3 up pulses inside one window → lock=0, lock_state=1 at that window end.
6. LOCKED, then freeze=1 with up held 100 clocks → ctrl_word constant, lock=1, lock_state=3. freeze=0 → lock_state=1, lock=0. enable=0 → ctrl_word=512 on the next edge.
